// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and parameter helpers for the button debounce bank
package debounce_pkg;

  // Per-channel long-press tracker states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } hold_state_t;

  function automatic int unsigned cycles_from_ms(input int unsigned clk_khz,
                                                 input int unsigned ms);
    return clk_khz * ms;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button channel: synchroniser, debounce, press/hold/repeat strobes
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned HOLD_CYCLES   = 20,
  parameter int unsigned REPEAT_CYCLES = 8,
  parameter int unsigned ACTIVE_LOW    = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  output logic level,
  output logic rise,
  output logic fall,
  output logic hold,
  output logic rpt
);

  localparam int unsigned DW = $clog2(DB_CYCLES + 1);
  // At least one bit so the counter exists even when hold/repeat are disabled
  localparam int unsigned HW = $clog2(max_u(max_u(HOLD_CYCLES, REPEAT_CYCLES), 1) + 1);
  localparam logic [DW-1:0] DB_TERM   = DW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_TERM = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [HW-1:0] REP_TERM  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic          POL       = (ACTIVE_LOW != 0);

  logic          s0, s1;
  logic [DW-1:0] dcnt;
  logic          flip;
  hold_state_t   state, state_d;
  logic [HW-1:0] hcnt, hcnt_d;
  logic          hold_d, rpt_d;

  // The debounced level changes on this edge
  assign flip = (s1 != level) && (dcnt == DB_TERM);

  // Polarity correction and two-flop synchroniser; reset value is "released"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= src ^ POL;
      s1 <= s0;
    end
  end

  // Stability counter: level follows s1 only after DB_CYCLES agreeing cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt  <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= flip & ~level;
      fall <= flip & level;
      if (s1 == level) begin
        dcnt <= '0;
      end else if (dcnt == DB_TERM) begin
        dcnt  <= '0;
        level <= ~level;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

  // Hold FSM state, counter and registered hold/repeat strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hcnt  <= '0;
      hold  <= 1'b0;
      rpt   <= 1'b0;
    end else begin
      state <= state_d;
      hcnt  <= hcnt_d;
      hold  <= hold_d;
      rpt   <= rpt_d;
    end
  end

  // Next-state logic: a release always wins and suppresses hold/repeat on that edge
  always_comb begin
    state_d = state;
    hcnt_d  = hcnt;
    hold_d  = 1'b0;
    rpt_d   = 1'b0;
    if (flip && level) begin
      state_d = IDLE;
      hcnt_d  = '0;
    end else begin
      case (state)
        IDLE: begin
          hcnt_d = '0;
          if (flip && !level && (HOLD_CYCLES != 0)) begin
            state_d = PRESSED;
          end
        end
        PRESSED: begin
          if (hcnt == HOLD_TERM) begin
            hold_d  = 1'b1;
            state_d = HELD;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt + HW'(1);
          end
        end
        HELD: begin
          if (REPEAT_CYCLES != 0) begin
            if (hcnt == REP_TERM) begin
              rpt_d  = 1'b1;
              hcnt_d = '0;
            end else begin
              hcnt_d = hcnt + HW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          hcnt_d  = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel push-button conditioner for the stopwatch front panel
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned CLK_FREQ_KHZ = 100_000,
  parameter int unsigned DEBOUNCE_MS  = 1,
  parameter int unsigned HOLD_MS      = 1000,
  parameter int unsigned REPEAT_MS    = 200,
  parameter int unsigned ACTIVE_LOW   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] src,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] hold,
  output logic [CHANNELS-1:0] rpt
);

  localparam int unsigned DB_CYCLES     = cycles_from_ms(CLK_FREQ_KHZ, DEBOUNCE_MS);
  localparam int unsigned HOLD_CYCLES   = cycles_from_ms(CLK_FREQ_KHZ, HOLD_MS);
  localparam int unsigned REPEAT_CYCLES = cycles_from_ms(CLK_FREQ_KHZ, REPEAT_MS);

  // A long press must be distinguishable from the debounce interval itself
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("debounce_bank: DB_CYCLES must be at least 1");
  end
  if ((HOLD_CYCLES != 0) && (HOLD_CYCLES <= DB_CYCLES)) begin : g_bad_hold
    $error("debounce_bank: HOLD_CYCLES must be 0 or greater than DB_CYCLES");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .src  (src[i]),
      .level(level[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .hold (hold[i]),
      .rpt  (rpt[i])
    );
  end

endmodule
